fb_swap_ctrl: RTL and testbench



---
 rtl/fb_pkg.sv | 15 +
 rtl/fb_ram.sv | 28 ++
 rtl/fb_swap_ctrl.sv | 157 +++++++++++++++
 tb/tb_fb_swap_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and defaults for the double-buffered frame-buffer controller.
package fb_pkg;

  localparam int unsigned FB_ADDR_W  = 10;
  localparam int unsigned FB_DATA_W  = 12;
  localparam int unsigned HALF_WORDS = 2 ** FB_ADDR_W;

  typedef enum logic [1:0] {
    StIdle,
    StPend,
    StAck,
    StClr
  } fb_state_t;

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port 1R1W memory with synchronous read.
// Written so that synthesis infers block RAM.
module fb_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Write port plus registered read port; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fb_swap_ctrl.sv
// Double-buffered frame-buffer controller.
// The display reads the front bank, the renderer writes the back bank, and a
// swap request takes effect only at the frame wrap (last address -> 0).
// Optional build macro FB_AUTO_CLEAR_EN: zero-fills the new back bank after
// every swap and after reset.
module fb_swap_ctrl
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W = FB_ADDR_W,
  parameter int unsigned DATA_W = FB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] din_top,
  output logic [DATA_W-1:0] din_btm,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              front_sel
);

`ifdef FB_AUTO_CLEAR_EN
  localparam fb_state_t RstState = StClr;
`else
  localparam fb_state_t RstState = StIdle;
`endif

  fb_state_t         state_q, state_d;
  logic              front_sel_q, front_sel_d;
  logic [ADDR_W-1:0] prev_addr_q;
  logic              rd_sel_q;    // front_sel at the time of the read in flight
  logic              rd_valid_q;  // first read since reset has completed
  logic              frame_bnd;

  logic              we_en;
  logic              we_half;
  logic [ADDR_W-1:0] we_addr;
  logic [DATA_W-1:0] we_data;
  logic [DATA_W-1:0] rd_data [4];  // index = {bank, half}

  // Only the bottom-row to top-row wrap rewinds to 0 from the last address.
  assign frame_bnd = (prev_addr_q == {ADDR_W{1'b1}}) && (r_addr == '0);

  assign wr_ready  = (state_q == StIdle);
  assign swap_ack  = (state_q == StAck);
  assign front_sel = front_sel_q;

  // State, bank select and read-path bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RstState;
      front_sel_q <= 1'b0;
      prev_addr_q <= '0;
      rd_sel_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      prev_addr_q <= r_addr;
      rd_sel_q    <= front_sel_q;
      rd_valid_q  <= 1'b1;
    end
  end

`ifdef FB_AUTO_CLEAR_EN
  logic [ADDR_W:0] clr_cnt_q, clr_cnt_d;

  // Clear-walk counter covering both halves of the back bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt_q <= '0;
    end else begin
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Counter advances only while clearing; otherwise parked at 0.
  always_comb begin
    clr_cnt_d = '0;
    if (state_q == StClr) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
    end
  end
`endif

  // Swap scheduling FSM: requests wait in StPend for the next frame wrap.
  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    case (state_q)
      StIdle: begin
        if (swap_req) begin
          state_d = StPend;
        end
      end
      StPend: begin
        if (frame_bnd) begin
          front_sel_d = ~front_sel_q;
          state_d     = StAck;
        end
      end
`ifdef FB_AUTO_CLEAR_EN
      StAck: state_d = StClr;
      StClr: begin
        if (clr_cnt_q == {(ADDR_W+1){1'b1}}) begin
          state_d = StIdle;
        end
      end
`else
      StAck: state_d = StIdle;
      StClr: state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  // Back-bank write port: renderer writes, or zero-fill while clearing.
  always_comb begin
    we_en   = wr_valid & wr_ready;
    we_half = wr_addr[ADDR_W];
    we_addr = wr_addr[ADDR_W-1:0];
    we_data = wr_data;
`ifdef FB_AUTO_CLEAR_EN
    if (state_q == StClr) begin
      we_en   = 1'b1;
      we_half = clr_cnt_q[ADDR_W];
      we_addr = clr_cnt_q[ADDR_W-1:0];
      we_data = '0;
    end
`endif
  end

  for (genvar g = 0; g < 4; g++) begin : g_bank
    localparam logic Bank = 1'(g / 2);
    localparam logic Half = 1'(g % 2);

    fb_ram #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
    ) u_ram (
      .clk  (clk),
      .we   (we_en && (~front_sel_q == Bank) && (we_half == Half)),
      .waddr(we_addr),
      .wdata(we_data),
      .raddr(r_addr),
      .rdata(rd_data[g])
    );
  end

  assign din_top = rd_valid_q ? rd_data[{rd_sel_q, 1'b0}] : '0;
  assign din_btm = rd_valid_q ? rd_data[{rd_sel_q, 1'b1}] : '0;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Directed self-checking bench for fb_swap_ctrl.
module tb_fb_swap_ctrl;

`ifdef FB_AUTO_CLEAR_EN
  localparam bit ClrEn = 1'b1;
`else
  localparam bit ClrEn = 1'b0;
`endif
  localparam int ClrCycles = ClrEn ? 2048 : 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  r_addr = '0;
  logic [11:0] din_top, din_btm;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [10:0] wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        swap_req = 1'b0;
  logic        swap_ack;
  logic        front_sel;

  int checks = 0;
  int failures = 0;

  fb_swap_ctrl u_dut (
    .clk      (clk),
    .rst      (rst),
    .r_addr   (r_addr),
    .din_top  (din_top),
    .din_btm  (din_btm),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .swap_req (swap_req),
    .swap_ack (swap_ack),
    .front_sel(front_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [10:0] a, input logic [11:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a);
    r_addr = a;
    tick();
  endtask

  // Wait (bounded) for the controller to accept writes; checks clear length.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!wr_ready && n < 5000) begin
      tick();
      n++;
    end
    check(tag, n, ClrCycles);
  endtask

  // Frame wrap 1023 -> 0 with swap_req held; checks the ack lands right after.
  task automatic do_swap(input string tag, input logic exp_front);
    rd(10'd1023);
    check({tag, "_noack_pre"}, swap_ack, 1'b0);
    rd(10'd0);
    check({tag, "_ack"}, swap_ack, 1'b1);
    check({tag, "_front"}, front_sel, exp_front);
    swap_req = 1'b0;
    tick();
    check({tag, "_ack_once"}, swap_ack, 1'b0);
    wait_ready({tag, "_clr_len"});
  endtask

  initial begin
    // Reset behaviour.
    rst = 1'b1;
    tick();
    check("rst_front", front_sel, 1'b0);
    check("rst_ack", swap_ack, 1'b0);
    check("rst_ready", wr_ready, !ClrEn);
    check("rst_din_top", din_top, 12'h000);
    check("rst_din_btm", din_btm, 12'h000);
    tick();
    rst = 1'b0;
    wait_ready("rst_clr_len");

    // Writes go to back bank B; display keeps reading A.
    wr(11'h005, 12'hF00);
    rd(10'd5);
    check("a_not_b", din_top == 12'hF00, 1'b0);
    check("front_a", front_sel, 1'b0);

    // Load B, then swap at the frame wrap.
    wr(11'h005, 12'h0F0);
    wr(11'h405, 12'h00F);
    swap_req = 1'b1;
    tick();
    check("pend_ready", wr_ready, 1'b0);
    do_swap("swap1", 1'b1);
    rd(10'd5);
    check("b_top", din_top, 12'h0F0);
    check("b_btm", din_btm, 12'h00F);

    // Load A while B is displayed.
    wr(11'h005, 12'hABC);
    wr(11'h405, 12'h123);
    rd(10'd5);
    check("b_still_top", din_top, 12'h0F0);

    // In-row address rewinds must not trigger the swap.
    swap_req = 1'b1;
    rd(10'd0);
    for (int a = 1; a < 64; a++) begin
      rd(10'(a));
      if (swap_ack) check("row_noack", swap_ack, 1'b0);
    end
    rd(10'd0);
    check("row_ack", swap_ack, 1'b0);
    check("row_ready", wr_ready, 1'b0);
    check("row_front", front_sel, 1'b1);
    do_swap("swap2", 1'b0);
    rd(10'd5);
    check("a_top", din_top, 12'hABC);
    check("a_btm", din_btm, 12'h123);

    // Request coinciding with the wrap in IDLE waits for the next wrap.
    rd(10'd1023);
    swap_req = 1'b1;
    rd(10'd0);
    check("coinc_ack", swap_ack, 1'b0);
    check("coinc_front", front_sel, 1'b0);
    rd(10'd1);
    check("coinc_ack2", swap_ack, 1'b0);
    check("coinc_front2", front_sel, 1'b0);
    do_swap("swap3", 1'b1);
    rd(10'd5);
    check("b_again_top", din_top, ClrEn ? 12'h000 : 12'h0F0);
    check("b_again_btm", din_btm, ClrEn ? 12'h000 : 12'h00F);

    // Reset while pending: no ack, front back to A.
    swap_req = 1'b1;
    tick();
    check("pend2_ready", wr_ready, 1'b0);
    rst = 1'b1;
    swap_req = 1'b0;
    tick();
    rst = 1'b0;
    check("rstp_front", front_sel, 1'b0);
    check("rstp_ack", swap_ack, 1'b0);
    check("rstp_ready", wr_ready, !ClrEn);
    check("rstp_din", din_top, 12'h000);
    wait_ready("rstp_clr_len");
    rd(10'd1023);
    rd(10'd0);
    check("rstp_noack", swap_ack, 1'b0);
    tick();
    check("rstp_noack2", swap_ack, 1'b0);
    check("rstp_front2", front_sel, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
